// File: rtl/lane_gene_collector_pkg.sv
// Shared types and defaults for the lane gene collector.
// Field constants exist only when LANE_COLLECT_NODE_MAX_EN is defined.
package lane_gene_collector_pkg;

    localparam int GENE_SZ_DEF = 64;
    localparam int ATTR_SZ_DEF = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int CNT_SZ_DEF  = 16;

`ifdef LANE_COLLECT_NODE_MAX_EN
    // Attribute field indices inside a gene (field k occupies [(k+1)*ATTR_SZ-1 : k*ATTR_SZ]).
    localparam int NODE_ID_FLD   = 5;
    localparam int CONN_FLAG_FLD = 6;
`endif

    // sel[k] names which burst input (0..2) lands in write slot k; n is the number of valid genes.
    typedef struct packed {
        logic [1:0]      n;
        logic [2:0][1:0] sel;
    } compact_t;

endpackage

// File: rtl/lane_gene_collector_compact.sv
// Burst compaction: maps the in_valid mask onto consecutive write slots
// in ascending input order and reports how many slots are used.
module lane_burst_compact
    import lane_gene_collector_pkg::*;
(
    input  logic [2:0] i_valid,
    output compact_t   o_cmp
);

    logic [1:0]      w_n;
    logic [2:0][1:0] w_sel;

    always_comb begin
        w_n = {1'b0, i_valid[0]} + {1'b0, i_valid[1]} + {1'b0, i_valid[2]};
        w_sel = '0;
        w_sel[0] = i_valid[0] ? 2'd0 : (i_valid[1] ? 2'd1 : 2'd2);
        w_sel[1] = (i_valid[0] && i_valid[1]) ? 2'd1 : 2'd2;
        // A third slot is only used by a full mask, so it is always gene 3.
        w_sel[2] = 2'd2;
    end

    assign o_cmp.n   = w_n;
    assign o_cmp.sel = w_sel;

endmodule

// File: rtl/lane_gene_collector.sv
// Lane gene collector: compacts 1-3 genes/cycle into a FWFT FIFO and drains one per cycle.
// Optional feature macro: LANE_COLLECT_NODE_MAX_EN (tracks max popped node id).
module lane_gene_collector
    import lane_gene_collector_pkg::*;
#(
    parameter int GENE_SZ = GENE_SZ_DEF,
    parameter int ATTR_SZ = ATTR_SZ_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_SZ  = CNT_SZ_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [GENE_SZ-1:0] gene_in1,
    input  logic [GENE_SZ-1:0] gene_in2,
    input  logic [GENE_SZ-1:0] gene_in3,
    input  logic [2:0]         in_valid,
    output logic               in_ready,
    output logic [GENE_SZ-1:0] gene_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_SZ-1:0]  gene_count,
    output logic               overflow_err,
    output logic [ATTR_SZ-1:0] hidden_node_max
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [GENE_SZ-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_SZ-1:0]  r_gene_count;
    logic               r_err;

    compact_t           w_cmp;
    logic               w_push;
    logic               w_pop;
    logic               w_in_ready;
    logic [PTR_W-1:0]   w_slot_ptr [4];
    logic [GENE_SZ-1:0] w_slot_data [3];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    lane_burst_compact u_compact (
        .i_valid (in_valid),
        .o_cmp   (w_cmp)
    );

    assign w_in_ready = (r_count <= CNT_W'(DEPTH - 3));
    assign w_push     = w_in_ready && (|in_valid) && !clear;
    assign w_pop      = (r_count != '0) && out_ready && !clear;

    // Each slot wraps on its own so a burst may straddle the end of the buffer.
    always_comb begin
        w_slot_ptr[0] = r_wr_ptr;
        for (int k = 1; k < 4; k++) begin
            w_slot_ptr[k] = ptr_inc(w_slot_ptr[k-1]);
        end
        for (int k = 0; k < 3; k++) begin
            case (w_cmp.sel[k])
                2'd0:    w_slot_data[k] = gene_in1;
                2'd1:    w_slot_data[k] = gene_in2;
                default: w_slot_data[k] = gene_in3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(w_cmp.n)) begin
                    r_mem[w_slot_ptr[k]] <= w_slot_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_gene_count <= '0;
            r_err        <= 1'b0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_gene_count <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_slot_ptr[w_cmp.n];
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
                if (r_gene_count != '1) begin
                    r_gene_count <= r_gene_count + 1'b1;
                end
            end
            r_count <= r_count + (w_push ? CNT_W'(w_cmp.n) : '0) - (w_pop ? CNT_W'(1) : '0);
            if ((|in_valid) && !w_in_ready) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = (r_count != '0);
    assign gene_out     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign gene_count   = r_gene_count;
    assign overflow_err = r_err;

`ifdef LANE_COLLECT_NODE_MAX_EN
    logic [ATTR_SZ-1:0] r_node_max;
    logic               w_is_conn;
    logic [ATTR_SZ-1:0] w_node_id;

    assign w_is_conn = gene_out[(CONN_FLAG_FLD + 1) * ATTR_SZ - 1];
    assign w_node_id = gene_out[NODE_ID_FLD * ATTR_SZ +: ATTR_SZ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_node_max <= '0;
        end else if (clear) begin
            r_node_max <= '0;
        end else if (w_pop && !w_is_conn && (w_node_id > r_node_max)) begin
            r_node_max <= w_node_id;
        end
    end

    assign hidden_node_max = r_node_max;
`else
    assign hidden_node_max = '0;
`endif

endmodule

// File: tb/tb_lane_gene_collector.sv
// Scoreboard bench for lane_gene_collector: DEPTH=8 and DEPTH=5 instances share stimulus,
// one instance is checked at a time against a queue model.
module tb_lane_gene_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [63:0] g1, g2, g3;
    logic [2:0]  iv;
    logic        ordy;

    logic        rdy8, ov8, err8, rdy5, ov5, err5;
    logic [63:0] go8, go5;
    logic [15:0] gc8, gc5;
    logic [7:0]  nm8, nm5;

    logic        use5;
    logic        cur_rdy, cur_ov, cur_err;
    logic [63:0] cur_go;
    logic [15:0] cur_gc;
    logic [7:0]  cur_nm;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    int          m_gcnt;
    bit          m_err;
    logic [7:0]  m_nmax;

    always #5 clk = ~clk;

    lane_gene_collector #(.GENE_SZ(64), .ATTR_SZ(8), .DEPTH(8), .CNT_SZ(16)) u_dut8 (
        .clk(clk), .rst(rst), .clear(clear),
        .gene_in1(g1), .gene_in2(g2), .gene_in3(g3), .in_valid(iv),
        .in_ready(rdy8), .gene_out(go8), .out_valid(ov8), .out_ready(ordy),
        .gene_count(gc8), .overflow_err(err8), .hidden_node_max(nm8)
    );

    lane_gene_collector #(.GENE_SZ(64), .ATTR_SZ(8), .DEPTH(5), .CNT_SZ(16)) u_dut5 (
        .clk(clk), .rst(rst), .clear(clear),
        .gene_in1(g1), .gene_in2(g2), .gene_in3(g3), .in_valid(iv),
        .in_ready(rdy5), .gene_out(go5), .out_valid(ov5), .out_ready(ordy),
        .gene_count(gc5), .overflow_err(err5), .hidden_node_max(nm5)
    );

    assign cur_rdy = use5 ? rdy5 : rdy8;
    assign cur_ov  = use5 ? ov5  : ov8;
    assign cur_err = use5 ? err5 : err8;
    assign cur_go  = use5 ? go5  : go8;
    assign cur_gc  = use5 ? gc5  : gc8;
    assign cur_nm  = use5 ? nm5  : nm8;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input bit conn, input logic [7:0] id);
        return {8'h00, (conn ? 8'h80 : 8'h00), id, 40'h0};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_gcnt = 0;
        m_err  = 1'b0;
        m_nmax = '0;
    endtask

    // Drive one cycle of stimulus, check outputs against the model, then advance the model.
    task automatic step(input logic [2:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic r);
        int          depth;
        bit          rdy;
        logic [63:0] g;
        @(negedge clk);
        clear = 1'b0;
        iv = v; g1 = a; g2 = b; g3 = c; ordy = r;
        #1;
        depth = use5 ? 5 : 8;
        rdy = (exp_q.size() <= depth - 3);
        check("in_ready", 64'(cur_rdy), 64'(rdy));
        check("out_valid", 64'(cur_ov), 64'(exp_q.size() != 0));
        check("gene_out", cur_go, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
        check("gene_count", 64'(cur_gc), 64'(m_gcnt));
        check("overflow_err", 64'(cur_err), 64'(m_err));
`ifdef LANE_COLLECT_NODE_MAX_EN
        check("node_max", 64'(cur_nm), 64'(m_nmax));
`else
        check("node_max", 64'(cur_nm), 64'h0);
`endif
        if (r && exp_q.size() != 0) begin
            g = exp_q.pop_front();
            if (m_gcnt < 65535) m_gcnt++;
            if (!g[55] && g[47:40] > m_nmax) m_nmax = g[47:40];
        end
        if (|v) begin
            if (rdy) begin
                if (v[0]) exp_q.push_back(a);
                if (v[1]) exp_q.push_back(b);
                if (v[2]) exp_q.push_back(c);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        iv = 3'b111; g1 = 64'hDEAD; g2 = 64'hBEEF; g3 = 64'hCAFE; ordy = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; iv = '0; ordy = 1'b0;
        g1 = '0; g2 = '0; g3 = '0; use5 = 1'b0;
        model_reset();

        // reset state
        step(3'b000, 0, 0, 0, 1'b0);
        check("rst_in_ready", 64'(rdy8), 64'h1);
        check("rst_out_valid", 64'(ov8), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // single gene, FWFT, pop
        step(3'b001, 64'hA, 64'h0, 64'h0, 1'b0);
        step(3'b000, 0, 0, 0, 1'b0);
        check("t1_gene_out", cur_go, 64'hA);
        step(3'b000, 0, 0, 0, 1'b1);
        step(3'b000, 0, 0, 0, 1'b0);
        check("t1_gene_count", 64'(cur_gc), 64'h1);

        // two full bursts fill to 6, then drain
        step(3'b111, 64'h1, 64'h2, 64'h3, 1'b0);
        step(3'b111, 64'h4, 64'h5, 64'h6, 1'b0);
        step(3'b000, 0, 0, 0, 1'b0);
        check("t2_in_ready_low", 64'(cur_rdy), 64'h0);
        repeat (6) step(3'b000, 0, 0, 0, 1'b1);

        // sparse mask 101
        step(3'b101, 64'hA, 64'hB, 64'hC, 1'b0);
        step(3'b000, 0, 0, 0, 1'b1);
        check("t3_head", cur_go, 64'hA);
        step(3'b000, 0, 0, 0, 1'b1);
        step(3'b000, 0, 0, 0, 1'b0);
        check("t3_empty", 64'(cur_ov), 64'h0);

        // overflow then clear
        step(3'b111, 64'h11, 64'h12, 64'h13, 1'b0);
        step(3'b111, 64'h14, 64'h15, 64'h16, 1'b0);
        step(3'b111, 64'h17, 64'h18, 64'h19, 1'b0);
        step(3'b000, 0, 0, 0, 1'b0);
        check("t4_overflow", 64'(cur_err), 64'h1);
        do_clear();
        step(3'b000, 0, 0, 0, 1'b0);
        check("t4_clr_err", 64'(cur_err), 64'h0);
        check("t4_clr_count", 64'(cur_gc), 64'h0);
        check("t4_clr_ready", 64'(cur_rdy), 64'h1);

        // DEPTH=5: continuous 011 with draining, then random traffic across the wrap
        do_clear();
        use5 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(3'b011, 64'h100 + 64'(2 * i), 64'h101 + 64'(2 * i), 64'h0, 1'b1);
        end
        repeat (6) step(3'b000, 0, 0, 0, 1'b1);
        do_clear();
        for (int i = 0; i < 80; i++) begin
            step(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        repeat (6) step(3'b000, 0, 0, 0, 1'b1);

        // node max tracking on DEPTH=8
        do_clear();
        use5 = 1'b0;
        step(3'b111, mk(1'b0, 8'd3), mk(1'b0, 8'd9), mk(1'b0, 8'd5), 1'b0);
        step(3'b001, mk(1'b1, 8'd200), 64'h0, 64'h0, 1'b0);
        repeat (5) step(3'b000, 0, 0, 0, 1'b1);
`ifdef LANE_COLLECT_NODE_MAX_EN
        check("t6_node_max", 64'(cur_nm), 64'd9);
`else
        check("t6_node_max", 64'(cur_nm), 64'd0);
`endif

        // reset mid-burst discards everything
        step(3'b111, 64'h21, 64'h22, 64'h23, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        iv = '0;
        model_reset();
        #1;
        check("rst_mid_valid", 64'(ov8), 64'h0);
        check("rst_mid_count", 64'(gc8), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step(3'b000, 0, 0, 0, 1'b1);
        step(3'b000, 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
